hdb3_decoder: RTL and testbench

//  Receive-side HDB3 decoder, the counterpart of the transmit chain's B-insertion and V-insertion stages.

---
 rtl/hdb3_pkg.sv | 18 +
 rtl/hdb3_viol_det.sv | 62 ++++++
 rtl/hdb3_decoder.sv | 100 ++++++++++
 tb/tb_hdb3_decoder.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/hdb3_pkg.sv
// Shared HDB3 receive-side symbol encodings and pipeline constants.
package hdb3_pkg;

  localparam logic [1:0] SYM_ZERO = 2'b00;
  localparam logic [1:0] SYM_POS  = 2'b10;
  localparam logic [1:0] SYM_NEG  = 2'b01;
  localparam logic [1:0] SYM_ILL  = 2'b11;

  // Classified symbol; HDB3_B can only be recognised in hindsight, so the decoder never emits it.
  typedef enum logic [1:0] {HDB3_0, HDB3_1, HDB3_V, HDB3_B} hdb3_code_e;

  localparam int DELAY = 3;

  function automatic logic is_pulse(input logic [1:0] s);
    return (s == SYM_POS) || (s == SYM_NEG);
  endfunction

endpackage

// File: rtl/hdb3_viol_det.sv
// Polarity tracker and V/mark classifier for the HDB3 decoder.
// With HDB3_ERR_CHK_EN it also flags a V repeating the previous V's polarity.
module hdb3_viol_det
  import hdb3_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] sym,
  output hdb3_code_e code
`ifdef HDB3_ERR_CHK_EN
  ,
  output logic       v_err
`endif
);

  logic pulse, pol;
  logic last_pol_q, last_pol_d;
  logic pol_known_q, pol_known_d;

  always_comb begin
    pulse       = is_pulse(sym);
    pol         = sym[1];
    code        = HDB3_0;
    if (pulse) code = (pol_known_q && (pol == last_pol_q)) ? HDB3_V : HDB3_1;
    last_pol_d  = pulse ? pol : last_pol_q;
    pol_known_d = pol_known_q | pulse;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_pol_q  <= 1'b0;
      pol_known_q <= 1'b0;
    end else begin
      last_pol_q  <= last_pol_d;
      pol_known_q <= pol_known_d;
    end
  end

`ifdef HDB3_ERR_CHK_EN
  logic v_seen_q, v_seen_d;
  logic last_v_pol_q, last_v_pol_d;
  logic is_v;

  always_comb begin
    is_v         = (code == HDB3_V);
    v_err        = is_v && v_seen_q && (pol == last_v_pol_q);
    v_seen_d     = v_seen_q | is_v;
    last_v_pol_d = is_v ? pol : last_v_pol_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_seen_q     <= 1'b0;
      last_v_pol_q <= 1'b0;
    end else begin
      v_seen_q     <= v_seen_d;
      last_v_pol_q <= last_v_pol_d;
    end
  end
`endif

endmodule

// File: rtl/hdb3_decoder.sv
// HDB3 line decoder: P/N rails in, NRZ out with fixed 3-edge latency; V and B pulses removed.
// Optional line-code checking is built when HDB3_ERR_CHK_EN is defined.
module hdb3_decoder
  import hdb3_pkg::*;
#(
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             line_p,
  input  logic             line_n,
  output logic             data_out,
  output logic             data_vld,
  output logic             v_det,
  output logic             code_err,
  output logic [ERR_W-1:0] err_cnt
);

  logic [1:0] sym;
  hdb3_code_e code;
  logic       is_v, mark;

  assign sym = {line_p, line_n};

`ifdef HDB3_ERR_CHK_EN
  logic v_err;
  hdb3_viol_det u_viol (.clk(clk), .rst_n(rst_n), .sym(sym), .code(code), .v_err(v_err));
`else
  hdb3_viol_det u_viol (.clk(clk), .rst_n(rst_n), .sym(sym), .code(code));
`endif

  logic [DELAY:0] sh_q, sh_d;
  logic [1:0]     fill_q, fill_d;
  logic           vld_q, vld_d;
  logic           v_det_q, v_det_d;

  // A V clears its own slot and the slot DELAY edges back, where a B would sit.
  always_comb begin
    is_v    = (code == HDB3_V);
    mark    = (code == HDB3_1);
    sh_d    = {(is_v ? 1'b0 : sh_q[DELAY-1]), sh_q[DELAY-2:0], mark};
    fill_d  = (fill_q == 2'd3) ? fill_q : fill_q + 2'd1;
    vld_d   = vld_q | (fill_q == 2'd3);
    v_det_d = is_v;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q    <= '0;
      fill_q  <= 2'd0;
      vld_q   <= 1'b0;
      v_det_q <= 1'b0;
    end else begin
      sh_q    <= sh_d;
      fill_q  <= fill_d;
      vld_q   <= vld_d;
      v_det_q <= v_det_d;
    end
  end

  assign data_out = sh_q[DELAY];
  assign data_vld = vld_q;
  assign v_det    = v_det_q;

`ifdef HDB3_ERR_CHK_EN
  logic [1:0]       zcnt_q, zcnt_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             code_err_q, code_err_d;
  logic             zero, zero_err;

  // Any non-zero symbol (illegal 11 included) breaks a zero run.
  always_comb begin
    zero       = (sym == SYM_ZERO);
    zero_err   = zero && (zcnt_q == 2'd3);
    zcnt_d     = (!zero || zero_err) ? 2'd0 : zcnt_q + 2'd1;
    code_err_d = (sym == SYM_ILL) || zero_err || v_err;
    err_cnt_d  = err_cnt_q;
    if (code_err_d && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + ERR_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zcnt_q     <= 2'd0;
      err_cnt_q  <= '0;
      code_err_q <= 1'b0;
    end else begin
      zcnt_q     <= zcnt_d;
      err_cnt_q  <= err_cnt_d;
      code_err_q <= code_err_d;
    end
  end

  assign code_err = code_err_q;
  assign err_cnt  = err_cnt_q;
`else
  assign code_err = 1'b0;
  assign err_cnt  = '0;
`endif

endmodule

// File: tb/tb_hdb3_decoder.sv
// Self-checking bench for hdb3_decoder: directed HDB3 sequences plus random symbols vs a queue model.
module tb_hdb3_decoder;

  localparam int ERR_W = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             line_p = 1'b0;
  logic             line_n = 1'b0;
  logic             data_out, data_vld, v_det, code_err;
  logic [ERR_W-1:0] err_cnt;

  hdb3_decoder #(.ERR_W(ERR_W)) dut (
    .clk(clk), .rst_n(rst_n), .line_p(line_p), .line_n(line_n),
    .data_out(data_out), .data_vld(data_vld), .v_det(v_det),
    .code_err(code_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: decoded bits since reset, V-erasure applied retroactively.
  bit dec[$];
  bit known, last_pol, v_seen, last_v_pol;
  int zrun, exp_cnt;
  bit exp_v, exp_err;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v8);
    n_assert++;
    assert (obs === exp_v8) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v8);
    end
  endtask

  task automatic model_reset();
    dec.delete();
    known = 0; last_pol = 0; v_seen = 0; last_v_pol = 0;
    zrun = 0; exp_cnt = 0; exp_v = 0; exp_err = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n  = 1'b0;
    line_p = 1'b0;
    line_n = 1'b0;
    #1;
    chk("rst data_out", 8'(data_out), 8'd0);
    chk("rst data_vld", 8'(data_vld), 8'd0);
    chk("rst v_det",    8'(v_det),    8'd0);
    chk("rst code_err", 8'(code_err), 8'd0);
    chk("rst err_cnt",  8'(err_cnt),  8'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One line symbol: drive, clock, advance model, compare every output.
  task automatic step(input logic p, input logic n);
    bit pulse, pol, isv, err, exp_d, exp_vld;
    int sz;
    line_p = p;
    line_n = n;
    @(posedge clk);
    #1;
    pulse = p ^ n;
    pol   = p;
    isv   = pulse && known && (pol == last_pol);
    dec.push_back(pulse && !isv);
    sz = dec.size();
    if (isv && sz >= 4) dec[sz-4] = 1'b0;
    err = p && n;
    if (!p && !n) begin
      zrun++;
      if (zrun == 4) begin err = 1; zrun = 0; end
    end else zrun = 0;
    if (isv) begin
      if (v_seen && pol == last_v_pol) err = 1;
      v_seen = 1;
      last_v_pol = pol;
    end
    if (pulse) begin known = 1; last_pol = pol; end
    exp_v = isv;
`ifdef HDB3_ERR_CHK_EN
    exp_err = err;
    if (err && exp_cnt < (1 << ERR_W) - 1) exp_cnt++;
`else
    exp_err = 0;
`endif
    exp_vld = (sz >= 4);
    exp_d   = (sz >= 4) ? dec[sz-4] : 1'b0;
    chk("data_out", 8'(data_out), 8'(exp_d));
    chk("data_vld", 8'(data_vld), 8'(exp_vld));
    chk("v_det",    8'(v_det),    8'(exp_v));
    chk("code_err", 8'(code_err), 8'(exp_err));
    chk("err_cnt",  8'(err_cnt),  8'(exp_cnt));
  endtask

  task automatic sp(); step(1'b1, 1'b0); endtask
  task automatic sn(); step(1'b0, 1'b1); endtask
  task automatic sz(); step(1'b0, 1'b0); endtask

  initial begin
    // 1: alternating marks
    do_reset();
    sp(); sn(); sp(); sn(); sp(); sz(); sz(); sz();
    chk("t1 data_out after flush", 8'(data_out), 8'd1);

    // 2: 000V
    do_reset();
    sp(); sz(); sz(); sz(); sp();
    chk("t2 v_det pulse", 8'(v_det), 8'd1);
    sn(); sp(); sn();

    // 3: B00V after a mark
    do_reset();
    sp(); sn(); sz(); sz(); sn(); sp(); sn(); sp();

    // 4: three B00V with alternating V, then marks to flush
    do_reset();
    sp();
    sn(); sz(); sz(); sn();
    sp(); sz(); sz(); sp();
    sn(); sz(); sz(); sn();
    sp(); sn(); sp(); sn();

    // 5: illegal symbol, zero run, same-polarity V pair, then saturation
    do_reset();
    step(1'b1, 1'b1);
    sz(); sz(); sz(); sz();
    sp(); sp(); sp();
    step(1'b1, 1'b1); step(1'b1, 1'b1);
    sn(); sp();

    // 6: reset in the middle of B00V; first pulse afterwards is a mark
    do_reset();
    sp(); sn(); sz();
    do_reset();
    sn(); sz(); sz(); sz();
    chk("t6 first pulse decoded as mark", 8'(data_out), 8'd1);

    // random symbols with one mid-stream reset
    do_reset();
    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 15);
      if (i == 200) do_reset();
      if (r == 0)      step(1'b1, 1'b1);
      else if (r < 7)  sz();
      else if (r < 11) sp();
      else             sn();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
